ocp_interval_timer: RTL and testbench



---
 rtl/ocp_interval_timer.sv | 207 ++++++++++++++++++++
 tb/tb_ocp_interval_timer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ocp_interval_timer.sv
// ocp_interval_timer: down-counting interval timer on the OCP bus.
// A period loaded into CNTR is counted down in CURR once CTRL.enable is set.
// On expiry the timer flags ipend (when imask is set), then either reloads
// from CNTR or stops. Every accepted command gets a DVA one cycle later.
module ocp_interval_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_MAddr,
  input  logic [2:0]  i_MCmd,
  input  logic [31:0] i_MData,
  input  logic [3:0]  i_MByteEn,
  output logic        o_SCmdAccept,
  output logic [31:0] o_SData,
  output logic [1:0]  o_SResp,
  output logic        o_intr
);

  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_CNTR  = 2'd1;
  localparam logic [1:0] REG_CURR  = 2'd2;

  // Replace only the bytes whose enable is set.
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Architectural state.
  logic        r_enable;
  logic        r_reload;
  logic        r_imask;
  logic        r_ipend;
  logic [31:0] r_cntr;
  logic [31:0] r_curr;

  // Response / interrupt output registers.
  logic [1:0]  r_sresp;
  logic [31:0] r_sdata;
  logic        r_intr;

  // Command decode.
  logic        w_is_write;
  logic        w_is_read;
  logic [1:0]  w_sel;
  logic        w_ctrl_wr;
  logic        w_cntr_wr;
  logic        w_running;
  logic        w_tick;
  logic        w_expire;

  // Next-state values.
  logic        w_enable_nxt;
  logic        w_reload_nxt;
  logic        w_imask_nxt;
  logic        w_ipend_nxt;
  logic [31:0] w_cntr_nxt;
  logic [31:0] w_curr_nxt;
  logic [31:0] w_rd_data;

  // Address bits outside [3:2] do not take part in decoding.
  logic        w_unused_addr;

  assign w_unused_addr = ^{i_MAddr[31:4], i_MAddr[1:0]};

  assign o_SCmdAccept = 1'b1;

  assign w_is_write = (i_MCmd == CMD_WRITE);
  assign w_is_read  = (i_MCmd == CMD_READ);
  assign w_sel      = i_MAddr[3:2];

  // CTRL fields live in byte 0, so a CTRL write only counts when that byte is enabled.
  assign w_ctrl_wr  = w_is_write & (w_sel == REG_CTRL) & i_MByteEn[0];
  assign w_cntr_wr  = w_is_write & (w_sel == REG_CNTR);

  // A CTRL write takes precedence over counting in the same cycle.
  assign w_running  = r_enable & ~w_ctrl_wr;
  assign w_tick     = w_running & (r_curr > 32'd1);
  assign w_expire   = w_running & (r_curr <= 32'd1);

  // Next value of the CTRL fields (enable/reload/imask).
  always_comb begin
    w_enable_nxt = r_enable;
    w_reload_nxt = r_reload;
    w_imask_nxt  = r_imask;
    if (w_ctrl_wr) begin
      w_enable_nxt = i_MData[0];
      w_reload_nxt = i_MData[1];
      w_imask_nxt  = i_MData[2];
    end else if (w_expire && !r_reload) begin
      w_enable_nxt = 1'b0;
    end else begin
      w_enable_nxt = r_enable;
    end
  end

  // Pending flag: write-1-to-clear, with an expiry set taking priority.
  always_comb begin
    w_ipend_nxt = r_ipend;
    if (w_ctrl_wr && i_MData[3]) begin
      w_ipend_nxt = 1'b0;
    end else begin
      w_ipend_nxt = r_ipend;
    end
    if (w_expire && r_imask) begin
      w_ipend_nxt = 1'b1;
    end else begin
      w_ipend_nxt = w_ipend_nxt;
    end
  end

  // Current count: start/restart, decrement, reload or stop at zero.
  always_comb begin
    w_curr_nxt = r_curr;
    if (w_ctrl_wr) begin
      if (i_MData[0]) begin
        w_curr_nxt = r_cntr;
      end else begin
        w_curr_nxt = r_curr;
      end
    end else if (w_tick) begin
      w_curr_nxt = r_curr - 32'd1;
    end else if (w_expire) begin
      if (r_reload) begin
        w_curr_nxt = r_cntr;
      end else begin
        w_curr_nxt = 32'd0;
      end
    end else begin
      w_curr_nxt = r_curr;
    end
  end

  // Period register; a new value is only picked up at the next start or reload.
  always_comb begin
    w_cntr_nxt = r_cntr;
    if (w_cntr_wr) begin
      w_cntr_nxt = merge_bytes(r_cntr, i_MData, i_MByteEn);
    end else begin
      w_cntr_nxt = r_cntr;
    end
  end

  // Read mux, sampling register values as they stand at the command edge.
  always_comb begin
    w_rd_data = 32'd0;
    case (w_sel)
      REG_CTRL: w_rd_data = {28'd0, r_ipend, r_imask, r_reload, r_enable};
      REG_CNTR: w_rd_data = r_cntr;
      REG_CURR: w_rd_data = r_curr;
      default:  w_rd_data = 32'd0;
    endcase
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable <= 1'b0;
      r_reload <= 1'b0;
      r_imask  <= 1'b0;
      r_ipend  <= 1'b0;
      r_cntr   <= 32'd0;
      r_curr   <= 32'd0;
    end else begin
      r_enable <= w_enable_nxt;
      r_reload <= w_reload_nxt;
      r_imask  <= w_imask_nxt;
      r_ipend  <= w_ipend_nxt;
      r_cntr   <= w_cntr_nxt;
      r_curr   <= w_curr_nxt;
    end
  end

  // One-cycle DVA response per accepted command, plus the registered interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sresp <= RESP_NULL;
      r_sdata <= 32'd0;
      r_intr  <= 1'b0;
    end else begin
      r_sresp <= (w_is_read || w_is_write) ? RESP_DVA : RESP_NULL;
      r_sdata <= w_is_read ? w_rd_data : 32'd0;
      r_intr  <= w_ipend_nxt & w_imask_nxt;
    end
  end

  assign o_SResp = r_sresp;
  assign o_SData = r_sdata;
  assign o_intr  = r_intr;

endmodule

// File: tb/tb_ocp_interval_timer.sv
// Self-checking bench for ocp_interval_timer: directed scenarios followed by
// random bus traffic, all compared against a cycle-level behavioural model.
module tb_ocp_interval_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_MAddr;
  logic [2:0]  i_MCmd;
  logic [31:0] i_MData;
  logic [3:0]  i_MByteEn;
  logic        o_SCmdAccept;
  logic [31:0] o_SData;
  logic [1:0]  o_SResp;
  logic        o_intr;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit          m_en, m_rl, m_im, m_ip;
  logic [31:0] m_cntr, m_curr;
  logic [1:0]  m_resp;
  logic [31:0] m_rdata;
  logic        m_intr;

  ocp_interval_timer dut (
    .clk          (clk),
    .rst          (rst),
    .i_MAddr      (i_MAddr),
    .i_MCmd       (i_MCmd),
    .i_MData      (i_MData),
    .i_MByteEn    (i_MByteEn),
    .o_SCmdAccept (o_SCmdAccept),
    .o_SData      (o_SData),
    .o_SResp      (o_SResp),
    .o_intr       (o_intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return {28'd0, m_ip, m_im, m_rl, m_en};
      2'd1:    return m_cntr;
      2'd2:    return m_curr;
      default: return 32'd0;
    endcase
  endfunction

  // Apply one clock edge worth of the timer's rules to the model.
  task automatic model_step(input bit r, input logic [2:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
    logic [31:0] old_cntr;
    logic [1:0]  sel;
    bit          wr, rd;
    if (r) begin
      m_en = 0; m_rl = 0; m_im = 0; m_ip = 0;
      m_cntr = 32'd0; m_curr = 32'd0;
      m_resp = 2'd0; m_rdata = 32'd0; m_intr = 1'b0;
      return;
    end
    old_cntr = m_cntr;
    sel      = addr[3:2];
    wr       = (cmd == 3'd1);
    rd       = (cmd == 3'd2);
    m_resp   = (wr || rd) ? 2'd1 : 2'd0;
    m_rdata  = rd ? m_read(sel) : 32'd0;
    if (wr && sel == 2'd0 && be[0]) begin
      if (data[3]) m_ip = 0;
      m_en = data[0]; m_rl = data[1]; m_im = data[2];
      if (m_en) m_curr = old_cntr;
    end else if (m_en) begin
      if (m_curr > 32'd1) begin
        m_curr = m_curr - 32'd1;
      end else begin
        if (m_im) m_ip = 1;
        if (m_rl) m_curr = old_cntr;
        else begin
          m_curr = 32'd0;
          m_en   = 0;
        end
      end
    end
    if (wr && sel == 2'd1) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_cntr[8*b +: 8] = data[8*b +: 8];
    end
    m_intr = m_ip & m_im;
  endtask

  // Drive one bus cycle, advance the model, and compare all outputs after the edge.
  task automatic cyc(input bit r, input logic [2:0] cmd, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be);
    rst       = r;
    i_MCmd    = cmd;
    i_MAddr   = addr;
    i_MData   = data;
    i_MByteEn = be;
    @(posedge clk);
    model_step(r, cmd, addr, data, be);
    #1;
    chk("accept", {31'd0, o_SCmdAccept}, 32'd1);
    chk("sresp",  {30'd0, o_SResp}, {30'd0, m_resp});
    chk("sdata",  o_SData, m_rdata);
    chk("intr",   {31'd0, o_intr}, {31'd0, m_intr});
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    cyc(1'b0, 3'd1, addr, data, be);
  endtask

  task automatic rd(input logic [31:0] addr);
    cyc(1'b0, 3'd2, addr, 32'd0, 4'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  cmd;
    logic [31:0] addr, data;
    logic [3:0]  be;
    bit          r;
    rst = 1'b1; i_MCmd = 3'd0; i_MAddr = 32'd0; i_MData = 32'd0; i_MByteEn = 4'd0;

    // Reset state
    cyc(1'b1, 3'd0, 32'd0, 32'd0, 4'd0);
    cyc(1'b1, 3'd2, 32'd4, 32'd0, 4'd0);
    chk("reset_sresp", {30'd0, o_SResp}, 32'd0);

    // Periodic timer with interrupt, period 16
    wr(32'h4, 32'h10, 4'hF);
    wr(32'h0, 32'h7, 4'hF);
    rd(32'h0);  chk("rd_ctrl", o_SData, 32'h7); chk("rd_ctrl_dva", {30'd0, o_SResp}, 32'd1);
    rd(32'h4);  chk("rd_cntr", o_SData, 32'h10);
    rd(32'h8);  a = o_SData;
    idle(1);
    rd(32'h8);  b = o_SData;
    chk("curr_first", a, 32'h0E);
    chk("curr_diff", a - b, 32'd2);
    idle(10);   chk("intr_before_expiry", {31'd0, o_intr}, 32'd0);
    idle(1);    chk("intr_at_expiry", {31'd0, o_intr}, 32'd1);
    rd(32'h8);  chk("curr_wrap", o_SData, 32'h10);

    // Period change while running
    wr(32'h4, 32'h4, 4'hF);
    idle(13);
    rd(32'h8);  chk("curr_old_period_end", o_SData, 32'h1);
    rd(32'h8);  chk("curr_new_period", o_SData, 32'h4);
    idle(3);
    rd(32'h8);  chk("curr_new_period2", o_SData, 32'h4);
    chk("intr_held", {31'd0, o_intr}, 32'd1);

    // W1C of ipend with restart
    wr(32'h0, 32'hF, 4'hF); chk("intr_cleared", {31'd0, o_intr}, 32'd0);
    idle(3);    chk("intr_still_low", {31'd0, o_intr}, 32'd0);
    idle(1);    chk("intr_reassert", {31'd0, o_intr}, 32'd1);

    // One-shot, interrupt masked
    wr(32'h0, 32'h8, 4'hF);
    wr(32'h0, 32'h1, 4'hF);
    rd(32'h8);  chk("oneshot_4", o_SData, 32'd4);
    rd(32'h8);  chk("oneshot_3", o_SData, 32'd3);
    rd(32'h8);  chk("oneshot_2", o_SData, 32'd2);
    rd(32'h8);  chk("oneshot_1", o_SData, 32'd1);
    rd(32'h8);  chk("oneshot_0", o_SData, 32'd0);
    rd(32'h0);  chk("oneshot_ctrl", o_SData, 32'd0);
    chk("oneshot_intr", {31'd0, o_intr}, 32'd0);

    // Reset mid-count
    wr(32'h0, 32'h7, 4'hF);
    idle(2);
    cyc(1'b1, 3'd0, 32'd0, 32'd0, 4'd0);
    chk("rst_intr", {31'd0, o_intr}, 32'd0);
    rd(32'h0);  chk("rst_ctrl", o_SData, 32'd0);
    rd(32'h4);  chk("rst_cntr", o_SData, 32'd0);
    idle(6);
    rd(32'h8);  chk("rst_curr_stopped", o_SData, 32'd0);

    // Unmapped read and byte-enable write
    rd(32'hC);  chk("rd_unmapped", o_SData, 32'd0); chk("rd_unmapped_dva", {30'd0, o_SResp}, 32'd1);
    wr(32'h4, 32'h11223344, 4'hF);
    wr(32'h4, 32'hAABBCCDD, 4'b0010);
    rd(32'h4);  chk("cntr_byte1", o_SData, 32'h1122CC44);
    wr(32'h8, 32'h55, 4'hF);
    rd(32'h8);  chk("curr_ro", o_SData, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      r    = ($urandom_range(0, 199) == 0);
      cmd  = 3'($urandom_range(0, 7));
      addr = $urandom;
      data = $urandom;
      if (addr[3:2] == 2'd1) data = 32'($urandom_range(0, 12));
      be   = 4'($urandom_range(0, 15));
      cyc(r, cmd, addr, data, be);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
